// File: rtl/wb_regfile_if.sv
// MEM/WB write-back and register read-port signal bundle for wb_regfile.
// master = pipeline side driving write-back and read indices; slave = register file.
interface wb_regfile_if;
    logic        RegWrite_MEM_WB;
    logic        MemtoReg_MEM_WB;
    logic        JAL_MEM_WB;
    logic [4:0]  WriteRegister_MEM_WB;
    logic [31:0] ReadMemData_MEM_WB;
    logic [31:0] ALUResult_MEM_WB;
    logic [31:0] BranchResult_MEM_WB;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [31:0] WriteData_WB;
    logic [31:0] RetireCount;

    modport master (
        output RegWrite_MEM_WB, MemtoReg_MEM_WB, JAL_MEM_WB, WriteRegister_MEM_WB,
        output ReadMemData_MEM_WB, ALUResult_MEM_WB, BranchResult_MEM_WB,
        output ReadRegister1, ReadRegister2,
        input  ReadData1, ReadData2, WriteData_WB, RetireCount
    );

    modport slave (
        input  RegWrite_MEM_WB, MemtoReg_MEM_WB, JAL_MEM_WB, WriteRegister_MEM_WB,
        input  ReadMemData_MEM_WB, ALUResult_MEM_WB, BranchResult_MEM_WB,
        input  ReadRegister1, ReadRegister2,
        output ReadData1, ReadData2, WriteData_WB, RetireCount
    );
endinterface

// File: rtl/wb_regfile.sv
// 32x32 MIPS register file with write-back select, JAL link write and retire counter.
// Optional macro WB_BYPASS_EN: read ports forward the pending write-back data.
module wb_regfile #(
    parameter logic [31:0] SP_INIT = 32'h7FFF_EFFC,
    parameter logic [31:0] GP_INIT = 32'h1000_8000
) (
    input  logic         clk,
    input  logic         reset,
    wb_regfile_if.slave  bus
);
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic [31:0] retire_cnt_q;
    logic [31:0] retire_cnt_d;

    logic [31:0] wr_data;
    logic [4:0]  wr_dest;
    logic        wr_en;

    function automatic logic [31:0] reset_value(input int idx);
        if (idx == 28) return GP_INIT;
        if (idx == 29) return SP_INIT;
        return 32'h0;
    endfunction

    // JAL takes priority over both data source and destination.
    always_comb begin
        if (bus.JAL_MEM_WB)           wr_data = bus.BranchResult_MEM_WB;
        else if (bus.MemtoReg_MEM_WB) wr_data = bus.ReadMemData_MEM_WB;
        else                          wr_data = bus.ALUResult_MEM_WB;
        wr_dest = bus.JAL_MEM_WB ? 5'd31 : bus.WriteRegister_MEM_WB;
        wr_en   = (bus.RegWrite_MEM_WB || bus.JAL_MEM_WB) && (wr_dest != 5'd0);
    end

    always_comb begin
        regs_d       = regs_q;
        retire_cnt_d = retire_cnt_q;
        if (wr_en) begin
            regs_d[wr_dest] = wr_data;
            retire_cnt_d    = retire_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= reset_value(i);
            retire_cnt_q <= 32'h0;
        end else begin
            regs_q       <= regs_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Register 0 is hard-wired to zero and never bypassed.
    always_comb begin
        bus.ReadData1 = (bus.ReadRegister1 == 5'd0) ? 32'h0 : regs_q[bus.ReadRegister1];
        bus.ReadData2 = (bus.ReadRegister2 == 5'd0) ? 32'h0 : regs_q[bus.ReadRegister2];
`ifdef WB_BYPASS_EN
        if (wr_en && (bus.ReadRegister1 == wr_dest)) bus.ReadData1 = wr_data;
        if (wr_en && (bus.ReadRegister2 == wr_dest)) bus.ReadData2 = wr_data;
`else
`endif
    end

    assign bus.WriteData_WB = wr_data;
    assign bus.RetireCount  = retire_cnt_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: driver pushes expected outputs per cycle, monitor pops and compares.
module tb_wb_regfile;
    logic clk;
    logic reset;

    wb_regfile_if bus ();

    wb_regfile dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] wd;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb [$];
    event        chk_ev;
    int          n_cmp;
    int          n_fail;

    logic [31:0] mdl [32];
    logic [31:0] cnt_m;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        mdl[28] = 32'h1000_8000;
        mdl[29] = 32'h7FFF_EFFC;
        cnt_m   = 32'h0;
    endtask

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", nm, act, req);
        end
    endtask

    // Monitor: samples 1ns after the driver announces a settled cycle, well before the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            #1;
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_empty: got 0 entries, expected 1");
            end else begin
                e = sb.pop_front();
                cmp({e.nm, ".rd1"}, bus.ReadData1, e.rd1);
                cmp({e.nm, ".rd2"}, bus.ReadData2, e.rd2);
                cmp({e.nm, ".wd"},  bus.WriteData_WB, e.wd);
                cmp({e.nm, ".cnt"}, bus.RetireCount, e.cnt);
            end
        end
    end

    // One MEM/WB cycle: drive on the falling edge, predict, then let the rising edge commit.
    task automatic cycle(input logic rw, input logic m2r, input logic jal, input logic [4:0] wr,
                         input logic [31:0] rmd, input logic [31:0] alu, input logic [31:0] br,
                         input logic [4:0] r1, input logic [4:0] r2, input string nm,
                         input bit rst_edge = 1'b0);
        exp_t        e;
        logic [31:0] wd;
        logic [4:0]  dest;
        logic        we;
        bit          byp;
        @(negedge clk);
        bus.RegWrite_MEM_WB      = rw;
        bus.MemtoReg_MEM_WB      = m2r;
        bus.JAL_MEM_WB           = jal;
        bus.WriteRegister_MEM_WB = wr;
        bus.ReadMemData_MEM_WB   = rmd;
        bus.ALUResult_MEM_WB     = alu;
        bus.BranchResult_MEM_WB  = br;
        bus.ReadRegister1        = r1;
        bus.ReadRegister2        = r2;
        #2;
        wd   = jal ? br : (m2r ? rmd : alu);
        dest = jal ? 5'd31 : wr;
        we   = (rw || jal) && (dest != 5'd0);
`ifdef WB_BYPASS_EN
        byp = 1'b1;
`else
        byp = 1'b0;
`endif
        e.nm  = nm;
        e.rd1 = (r1 == 5'd0) ? 32'h0 : ((byp && we && r1 == dest) ? wd : mdl[r1]);
        e.rd2 = (r2 == 5'd0) ? 32'h0 : ((byp && we && r2 == dest) ? wd : mdl[r2]);
        e.wd  = wd;
        e.cnt = cnt_m;
        sb.push_back(e);
        ->chk_ev;
        if (rst_edge) begin
            model_reset();
        end else if (reset && we) begin
            mdl[dest] = wd;
            cnt_m     = cnt_m + 32'd1;
        end
        @(posedge clk);
        if (rst_edge) reset = 1'b0;
        #1;
        bus.RegWrite_MEM_WB = 1'b0;
        bus.JAL_MEM_WB      = 1'b0;
        if (rst_edge) begin
            #2;
            reset = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b0;
        bus.RegWrite_MEM_WB      = 1'b0;
        bus.MemtoReg_MEM_WB      = 1'b0;
        bus.JAL_MEM_WB           = 1'b0;
        bus.WriteRegister_MEM_WB = 5'd0;
        bus.ReadMemData_MEM_WB   = 32'h0;
        bus.ALUResult_MEM_WB     = 32'h0;
        bus.BranchResult_MEM_WB  = 32'h0;
        bus.ReadRegister1        = 5'd0;
        bus.ReadRegister2        = 5'd0;
        model_reset();

        // Writes requested while reset is held must not land.
        cycle(1, 0, 0, 5'd5, 32'h0, 32'h1111_2222, 32'h0, 5'd29, 5'd28, "rst_hold");
        reset = 1'b1;
        cycle(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd29, 5'd28, "rst_vals");
        cycle(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd5, "reg5_zero");

        cycle(1, 0, 0, 5'd8, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd8, 5'd0, "alu_wr8");
        cycle(1, 1, 0, 5'd8, 32'h1234_5678, 32'h0BAD_0BAD, 32'h0, 5'd8, 5'd8, "mem_wr8");
        cycle(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd8, 5'd4, "rd8");

        cycle(0, 0, 1, 5'd4, 32'h0, 32'h5555_5555, 32'h0040_0008, 5'd31, 5'd4, "jal");
        cycle(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd31, 5'd4, "rd31");

        cycle(1, 0, 0, 5'd0, 32'h0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0, "wr0");
        cycle(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd8, "rd0");

        cycle(1, 0, 0, 5'd9, 32'h0, 32'hA5A5_A5A5, 32'h0, 5'd9, 5'd9, "byp9");
        cycle(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd9, 5'd9, "rd9");

        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        cnt_m = 32'hFFFF_FFFF;
        cycle(1, 0, 0, 5'd3, 32'h0, 32'h0000_0033, 32'h0, 5'd3, 5'd8, "cnt_max");
        cycle(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd9, "cnt_wrap");

        cycle(1, 0, 0, 5'd29, 32'h0, 32'hCAFE_F00D, 32'h0, 5'd29, 5'd8, "rst_edge", 1'b1);
        cycle(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd29, 5'd8, "post_rst");
        cycle(1, 0, 0, 5'd7, 32'h0, 32'h0707_0707, 32'h0, 5'd7, 5'd28, "first_wr");
        cycle(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd7, 5'd3, "rd7");

        for (int i = 0; i < 300; i++) begin
            logic [4:0] wr, r1, r2;
            wr = 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0), wr, $urandom, $urandom, $urandom,
                  r1, r2, "rand");
        end

        @(negedge clk);
        #5;
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb_drain: got %0d entries, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have parameter SP_INIT, default 32'h7FFF_EFFC, giving the reset value of register 29 ($sp).
REQ-002 The block SHALL have parameter GP_INIT, default 32'h1000_8000, giving the reset value of register 28 ($gp).
REQ-003 clk  input  1  the single clock; register writes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 RegWrite_MEM_WB  input  1  write request from the MEM/WB register.
REQ-006 MemtoReg_MEM_WB  input  1  1 = write ReadMemData_MEM_WB; 0 = write ALUResult_MEM_WB.
REQ-007 JAL_MEM_WB  input  1  1 = link write of BranchResult_MEM_WB into register 31.
REQ-008 WriteRegister_MEM_WB  input  5  destination register index.
REQ-009 ReadMemData_MEM_WB, ALUResult_MEM_WB, BranchResult_MEM_WB  input  32 each  write-back data candidates.
REQ-010 ReadRegister1, ReadRegister2  input  5 each  read port indices.
REQ-011 ReadData1, ReadData2  output  32 each  combinational read data.
REQ-012 WriteData_WB  output  32  selected write-back data, for the forwarding unit.
REQ-013 RetireCount  output  32  count of committed register writes.

Function
REQ-014 Data select SHALL be: JAL_MEM_WB=1 -> BranchResult_MEM_WB; otherwise MemtoReg_MEM_WB=1 -> ReadMemData_MEM_WB; otherwise ALUResult_MEM_WB. The result is driven on WriteData_WB combinationally.
REQ-015 Destination SHALL be 5'd31 when JAL_MEM_WB=1 and WriteRegister_MEM_WB otherwise.
REQ-016 A write SHALL commit on the rising clk edge when RegWrite_MEM_WB=1 or JAL_MEM_WB=1, and the destination is nonzero.
REQ-017 Register 0 SHALL always read 0. Writes to register 0 SHALL be discarded and not counted.
REQ-018 Reads SHALL be asynchronous: ReadDataN = reg[ReadRegisterN] with zero-cycle latency. The value written at a rising edge is visible before the following falling edge (write-first-half, read-second-half).
REQ-019 RetireCount SHALL increment by 1 on every committed write and wrap from 32'hFFFF_FFFF to 0.
REQ-020 Both read ports addressing the same register SHALL return identical data.
REQ-021 All inputs SHALL be held stable by the negedge-clocked MEM/WB stage. The block SHALL NOT sample on the falling edge.

Reset
REQ-022 While reset=0, all registers SHALL be 0 except reg28=GP_INIT and reg29=SP_INIT, and RetireCount SHALL be 0. This takes effect immediately, independent of clk.
REQ-023 Reset asserted during a write edge SHALL win: no write is committed and no count is taken.
REQ-024 After reset deassertion, the first rising clk edge SHALL accept a write normally.

Configuration
REQ-025 With macro WB_BYPASS_EN defined, a read port whose index equals a nonzero pending destination with a valid write request SHALL return WriteData_WB combinationally, in the same cycle, before the edge.
REQ-026 Without WB_BYPASS_EN, read ports SHALL return stored register contents only. REQ-018 timing alone then resolves the WB-to-ID hazard.
REQ-027 REQ-017 SHALL hold in both configurations; no bypass ever applies to register 0.

Verification
REQ-028 Reset release -> ReadRegister1=29 gives 32'h7FFF_EFFC; ReadRegister2=28 gives 32'h1000_8000; reg5 reads 0; RetireCount=0.
REQ-029 RegWrite=1, MemtoReg=0, WriteRegister=8, ALUResult=32'hDEAD_BEEF, rising edge -> reg8 reads DEADBEEF; RetireCount=1. Then MemtoReg=1, ReadMemData=32'h1234_5678 -> reg8=12345678; RetireCount=2.
REQ-030 JAL=1, RegWrite=0, WriteRegister=4, BranchResult=32'h0040_0008, rising edge -> reg31=00400008; reg4 unchanged.
REQ-031 RegWrite=1, WriteRegister=0, ALUResult=32'hFFFF_FFFF, rising edge -> reg0 reads 0; RetireCount unchanged.
REQ-032 WB_BYPASS_EN defined, RegWrite=1, WriteRegister=9, ALUResult=32'hA5A5_A5A5, ReadRegister1=9, before the edge -> ReadData1=A5A5A5A5. Undefined -> ReadData1 shows the old reg9 value until the edge.
REQ-033 Force RetireCount to 32'hFFFF_FFFF, then one committed write -> RetireCount=0. Assert reset coincident with a write edge -> reg state equals REQ-022 values.
